// File: rtl/ping_pong_monitor.sv
// ping_pong_monitor
//   Passive checker for a ping-pong counter stream. It keeps one reference
//   sample (pv, pd) and classifies each valid sample as hold, step, bounce
//   or flip. It counts bounces with saturation and latches the first
//   protocol violation as a sticky error code.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   valid             sample strobe
//   max, min          bounds of the observed counter (WIDTH bits)
//   value, direction  observed sample (direction: 0 up, 1 down)
//   step_evt          pulse: legal step, direction unchanged
//   bounce_max        pulse: legal turn-around at max
//   bounce_min        pulse: legal turn-around at min
//   flip_evt          pulse: legal mid-range reversal
//   bounce_cnt        saturating count of bounces (CNT_W bits)
//   locked            high while tracking
//   err, err_code     sticky error flag, code (1 range, 2 step, 3 turn)
module ping_pong_monitor #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [WIDTH-1:0] max,
  input  logic [WIDTH-1:0] min,
  input  logic [WIDTH-1:0] value,
  input  logic             direction,
  output logic             step_evt,
  output logic             bounce_max,
  output logic             bounce_min,
  output logic             flip_evt,
  output logic [CNT_W-1:0] bounce_cnt,
  output logic             locked,
  output logic             err,
  output logic [1:0]       err_code
);

  typedef enum logic [1:0] {IDLE, TRACK, ERROR} state_t;

  typedef enum logic [2:0] {
    C_HOLD, C_STEP, C_BMAX, C_BMIN, C_FLIP, C_ERANGE, C_ESTEP, C_ETURN
  } class_t;

  state_t           state;
  logic [WIDTH-1:0] pv;
  logic             pd;

  // Everything is compared one bit wider so that max+1 / 0-1 never wrap
  // back into the legal range.
  logic [WIDTH:0] v_x, max_x, min_x, pv_x;
  logic [WIDTH:0] pv_inc, pv_dec, max_dec, min_inc;
  logic           cfg_ok, in_range, same_dir, step_new;
  class_t         cls;

  always_comb begin
    v_x      = {1'b0, value};
    max_x    = {1'b0, max};
    min_x    = {1'b0, min};
    pv_x     = {1'b0, pv};
    pv_inc   = pv_x + (WIDTH+1)'(1);
    pv_dec   = pv_x - (WIDTH+1)'(1);
    max_dec  = max_x - (WIDTH+1)'(1);
    min_inc  = min_x + (WIDTH+1)'(1);
    cfg_ok   = max_x > min_x;
    in_range = (v_x <= max_x) && (v_x >= min_x);
    same_dir = direction == pd;
    // One step from pv in the direction of the new sample.
    step_new = direction ? (v_x == pv_dec) : (v_x == pv_inc);

    cls = C_ETURN;
    if (!in_range)
      cls = C_ERANGE;
    else if (same_dir && v_x == pv_x)
      cls = C_HOLD;
    else if (same_dir && step_new)
      cls = C_STEP;
    else if (!same_dir && pv_x == max_x && direction && v_x == max_dec)
      cls = C_BMAX;
    else if (!same_dir && pv_x == min_x && !direction && v_x == min_inc)
      cls = C_BMIN;
    else if (!same_dir && pv_x > min_x && pv_x < max_x && step_new)
      cls = C_FLIP;
    else if (same_dir)
      cls = C_ESTEP;
    else
      cls = C_ETURN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pv         <= '0;
      pd         <= 1'b0;
      step_evt   <= 1'b0;
      bounce_max <= 1'b0;
      bounce_min <= 1'b0;
      flip_evt   <= 1'b0;
      bounce_cnt <= '0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      step_evt   <= 1'b0;
      bounce_max <= 1'b0;
      bounce_min <= 1'b0;
      flip_evt   <= 1'b0;
      if (valid) begin
        case (state)
          IDLE: begin
            if (cfg_ok) begin
              if (!in_range) begin
                state    <= ERROR;
                err      <= 1'b1;
                err_code <= 2'd1;
              end else begin
                pv     <= value;
                pd     <= direction;
                state  <= TRACK;
                locked <= 1'b1;
              end
            end
          end
          TRACK: begin
            if (!cfg_ok) begin
              state  <= IDLE;
              locked <= 1'b0;
            end else if (cls == C_ERANGE || cls == C_ESTEP || cls == C_ETURN) begin
              state  <= ERROR;
              locked <= 1'b0;
              err    <= 1'b1;
              case (cls)
                C_ERANGE: err_code <= 2'd1;
                C_ESTEP:  err_code <= 2'd2;
                default:  err_code <= 2'd3;
              endcase
            end else begin
              pv <= value;
              pd <= direction;
              case (cls)
                C_STEP: step_evt   <= 1'b1;
                C_BMAX: bounce_max <= 1'b1;
                C_BMIN: bounce_min <= 1'b1;
                C_FLIP: flip_evt   <= 1'b1;
                default: ;
              endcase
              if ((cls == C_BMAX || cls == C_BMIN) && bounce_cnt != '1)
                bounce_cnt <= bounce_cnt + CNT_W'(1);
            end
          end
          ERROR: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
